// File: rtl/ddr3_user_port_arbiter_if.sv
// Requester-side ports and the DDR3 controller user interface shared by the port arbiter.
// The arbiter connects through the slave modport; user logic and the controller use master.
interface ddr3_user_port_arbiter_if #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 17,
  parameter int DQ_BITWIDTH = 16,
  parameter int STATE_W     = 5
);
  logic [NUM_PORTS-1:0]             p_req;
  logic [NUM_PORTS-1:0]             p_we;
  logic [NUM_PORTS*ADDR_W-1:0]      p_addr;
  logic [NUM_PORTS*DQ_BITWIDTH-1:0] p_wdata;
  logic [NUM_PORTS-1:0]             p_ack;
  logic [NUM_PORTS-1:0]             p_rvalid;
  logic [DQ_BITWIDTH-1:0]           p_rdata;
  logic                             write_enable;
  logic                             read_enable;
  logic [ADDR_W-1:0]                i_user_data_address;
  logic [DQ_BITWIDTH-1:0]           data_to_ram;
  logic [STATE_W-1:0]               main_state;
  logic [DQ_BITWIDTH-1:0]           data_from_ram;
  logic                             rd_data_valid;
  logic                             busy;
  logic                             rd_err;

  modport master (
    output p_req, p_we, p_addr, p_wdata, main_state, data_from_ram, rd_data_valid,
    input  p_ack, p_rvalid, p_rdata, write_enable, read_enable, i_user_data_address,
           data_to_ram, busy, rd_err
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, main_state, data_from_ram, rd_data_valid,
    output p_ack, p_rvalid, p_rdata, write_enable, read_enable, i_user_data_address,
           data_to_ram, busy, rd_err
  );
endinterface

// File: rtl/ddr3_user_port_arbiter.sv
// Round-robin sharing of the DDR3 controller user port among NUM_PORTS requesters, with a
// per-grant beat cap and an in-order port-ID FIFO that steers read data back to its issuer.
module ddr3_user_port_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int ADDR_W           = 17,
  parameter int DQ_BITWIDTH      = 16,
  parameter int STATE_W          = 5,
  parameter int STATE_WRITE_DATA = 8,
  parameter int STATE_READ_DATA  = 11,
  parameter int MAX_BURST        = 8,
  parameter int RD_FIFO_DEPTH    = 8
) (
  input logic                    clk,
  input logic                    resetn,
  ddr3_user_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int AW = $clog2(RD_FIFO_DEPTH);

  typedef enum logic {ST_ARB, ST_SERVE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PW-1:0]          r_owner, r_last_grant, w_pick;
  logic                   w_pick_valid;
  logic [BW-1:0]          r_beat_cnt;
  logic                   w_serving, w_release;
  logic                   w_owner_req, w_owner_we;
  logic [ADDR_W-1:0]      w_owner_addr;
  logic [DQ_BITWIDTH-1:0] w_owner_wdata;
  logic                   w_wr_en, w_rd_en, w_accept, w_push, w_pop;
  logic [NUM_PORTS-1:0]   w_ack, w_rvalid_nxt;
  logic [PW-1:0]          r_fifo_mem [RD_FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_fifo_cnt;
  logic                   w_fifo_full, w_fifo_empty;
  logic [NUM_PORTS-1:0]   r_rvalid;
  logic [DQ_BITWIDTH-1:0] r_rdata;
  logic                   r_rd_err;

  function automatic logic [PW-1:0] port_after(input logic [PW-1:0] base, input int k);
    return PW'((int'(base) + k) % NUM_PORTS);
  endfunction

  // Search starts just after the previous owner so every requester is reached within NUM_PORTS grants.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pick       = r_last_grant;
    w_pick_valid = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_pick_valid && bus.p_req[port_after(r_last_grant, k)]) begin
        w_pick       = port_after(r_last_grant, k);
        w_pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_owner_req   = 1'b0;
    w_owner_we    = 1'b0;
    w_owner_addr  = '0;
    w_owner_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_owner == PW'(i)) begin
        w_owner_req   = bus.p_req[i];
        w_owner_we    = bus.p_we[i];
        w_owner_addr  = bus.p_addr[i*ADDR_W +: ADDR_W];
        w_owner_wdata = bus.p_wdata[i*DQ_BITWIDTH +: DQ_BITWIDTH];
      end
    end
  end

  assign w_fifo_full  = (r_fifo_cnt == (AW+1)'(RD_FIFO_DEPTH));
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_serving    = (r_state == ST_SERVE);
  assign w_wr_en      = w_serving & w_owner_req & w_owner_we;
  assign w_rd_en      = w_serving & w_owner_req & ~w_owner_we & ~w_fifo_full;
  assign w_push       = w_rd_en & (bus.main_state == STATE_W'(STATE_READ_DATA));
  assign w_accept     = (w_wr_en & (bus.main_state == STATE_W'(STATE_WRITE_DATA))) | w_push;
  assign w_release    = ~w_owner_req | (w_accept & (r_beat_cnt == BW'(MAX_BURST - 1)));
  // Pop is judged on pre-push occupancy: a strobe into an empty FIFO is an error even if a push lands.
  assign w_pop        = bus.rd_data_valid & ~w_fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_ARB;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    case (r_state)
      ST_ARB:   if (w_pick_valid) w_state_nxt = ST_SERVE;
      ST_SERVE: if (w_release)    w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_ARB;
    endcase
    for (int i = 0; i < NUM_PORTS; i++) w_ack[i] = w_accept && (r_owner == PW'(i));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner      <= '0;
      r_last_grant <= PW'(NUM_PORTS - 1);
      r_beat_cnt   <= '0;
    end else if (r_state == ST_ARB) begin
      if (w_pick_valid) r_owner <= w_pick;
    end else if (w_release) begin
      r_last_grant <= r_owner;
      r_beat_cnt   <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + BW'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= r_owner;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_comb begin
    w_rvalid_nxt = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_rvalid_nxt[i] = w_pop && (r_fifo_mem[r_rd_ptr] == PW'(i));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rd_err <= 1'b0;
    end else begin
      r_rvalid <= w_rvalid_nxt;
      if (w_pop) r_rdata <= bus.data_from_ram;
      if (bus.rd_data_valid && w_fifo_empty) r_rd_err <= 1'b1;
    end
  end

  assign bus.p_ack               = w_ack;
  assign bus.p_rvalid            = r_rvalid;
  assign bus.p_rdata             = r_rdata;
  assign bus.write_enable        = w_wr_en;
  assign bus.read_enable         = w_rd_en;
  assign bus.i_user_data_address = (w_wr_en | w_rd_en) ? w_owner_addr  : '0;
  assign bus.data_to_ram         = (w_wr_en | w_rd_en) ? w_owner_wdata : '0;
  assign bus.busy                = w_serving | ~w_fifo_empty;
  assign bus.rd_err              = r_rd_err;
endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Randomized and directed bench for ddr3_user_port_arbiter against a queue-based transaction model
// of grants, beat caps and the outstanding-read ID order.
module tb_ddr3_user_port_arbiter;
  localparam int NP    = 2;
  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int SW    = 5;
  localparam int WR_ST = 8;
  localparam int RD_ST = 11;
  localparam int MAXB  = 8;
  localparam int DEPTH = 8;
  localparam int OW    = 2*NP + 2*DW + AW + 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ddr3_user_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DQ_BITWIDTH(DW), .STATE_W(SW)) bus ();

  ddr3_user_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DQ_BITWIDTH(DW), .STATE_W(SW),
    .STATE_WRITE_DATA(WR_ST), .STATE_READ_DATA(RD_ST), .MAX_BURST(MAXB), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  op_t port_q [NP][$];

  // Transaction model: who holds the grant, beats used, and port IDs of reads not yet returned.
  bit            m_arb;
  int            m_owner, m_last, m_beats, m_rv_port;
  int            m_ids[$];
  logic [DW-1:0] m_rdata;
  bit            m_err;

  logic [NP-1:0] s_ack, s_rvalid;
  logic [DW-1:0] s_rdata, s_dtr;
  logic [AW-1:0] s_addr;
  logic          s_we, s_re, s_busy, s_err;

  task automatic model_reset();
    m_arb = 1; m_owner = 0; m_last = NP - 1; m_beats = 0;
    m_rv_port = -1; m_rdata = '0; m_err = 0;
    m_ids.delete();
  endtask

  task automatic apply_ports();
    for (int i = 0; i < NP; i++) begin
      if (port_q[i].size() > 0) begin
        bus.p_req[i] = 1'b1;
        bus.p_we[i]  = port_q[i][0].we;
        bus.p_addr[i*AW +: AW]  = port_q[i][0].addr;
        bus.p_wdata[i*DW +: DW] = port_q[i][0].data;
      end else begin
        bus.p_req[i] = 1'b0;
        bus.p_we[i]  = 1'b0;
        bus.p_addr[i*AW +: AW]  = '0;
        bus.p_wdata[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic model_eval(output logic [OW-1:0] e, output bit acc, output bit re_o);
    logic [NP-1:0] ack;
    logic [NP-1:0] rv;
    logic          we, re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ack = '0; rv = '0; we = 0; re = 0; a = '0; d = '0; acc = 0;
    if (!m_arb) begin
      we = bus.p_req[m_owner] & bus.p_we[m_owner];
      re = bus.p_req[m_owner] & ~bus.p_we[m_owner] & (m_ids.size() < DEPTH);
      if (we || re) begin
        a = bus.p_addr[m_owner*AW +: AW];
        d = bus.p_wdata[m_owner*DW +: DW];
      end
      acc = (we && bus.main_state == SW'(WR_ST)) || (re && bus.main_state == SW'(RD_ST));
      ack[m_owner] = acc;
    end
    if (m_rv_port >= 0) rv[m_rv_port] = 1'b1;
    re_o = re;
    e = {ack, rv, m_rdata, we, re, a, d, (!m_arb || m_ids.size() != 0), m_err};
  endtask

  task automatic model_step(input bit acc, input bit re_i);
    int            pre;
    logic [NP-1:0] req;
    pre = m_ids.size();
    req = bus.p_req;
    m_rv_port = -1;
    if (bus.rd_data_valid) begin
      if (pre > 0) begin
        m_rv_port = m_ids.pop_front();
        m_rdata   = bus.data_from_ram;
      end else begin
        m_err = 1;
      end
    end
    if (acc && re_i) m_ids.push_back(m_owner);
    if (m_arb) begin
      if (req != '0) begin
        for (int k = 1; k <= NP; k++) begin
          if (req[(m_last + k) % NP]) begin
            m_owner = (m_last + k) % NP;
            break;
          end
        end
        m_arb = 0;
      end
    end else if (!req[m_owner] || (acc && m_beats == MAXB - 1)) begin
      m_arb = 1; m_last = m_owner; m_beats = 0;
    end else if (acc) begin
      m_beats++;
    end
  endtask

  // One clock: sample outputs mid-cycle, advance model and requesters across the edge.
  task automatic run_cycle(output logic [OW-1:0] exp_v, output logic [OW-1:0] obs_v);
    bit            acc, re_m;
    logic [NP-1:0] acked;
    #2;
    model_eval(exp_v, acc, re_m);
    obs_v = {bus.p_ack, bus.p_rvalid, bus.p_rdata, bus.write_enable, bus.read_enable,
             bus.i_user_data_address, bus.data_to_ram, bus.busy, bus.rd_err};
    s_ack = bus.p_ack; s_rvalid = bus.p_rvalid; s_rdata = bus.p_rdata;
    s_we = bus.write_enable; s_re = bus.read_enable; s_addr = bus.i_user_data_address;
    s_dtr = bus.data_to_ram; s_busy = bus.busy; s_err = bus.rd_err;
    acked = bus.p_ack;
    @(posedge clk);
    model_step(acc, re_m);
    #1;
    bus.rd_data_valid = 1'b0;
    for (int i = 0; i < NP; i++)
      if (acked[i] && port_q[i].size() > 0) void'(port_q[i].pop_front());
    apply_ports();
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < NP; i++) port_q[i].delete();
    bus.main_state = '0; bus.rd_data_valid = 1'b0; bus.data_from_ram = '0;
    apply_ports();
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    cyc = 1;
  endtask

  task automatic add_op(input int p, input bit we, input int addr, input int data);
    op_t op;
    op.we = we; op.addr = AW'(addr); op.data = DW'(data);
    port_q[p].push_back(op);
  endtask

  task automatic test_reset();
    logic [OW-1:0] e, o;
    do_reset();
    resetn = 1'b0;
    #1;
    o = {bus.p_ack, bus.p_rvalid, bus.p_rdata, bus.write_enable, bus.read_enable,
         bus.i_user_data_address, bus.data_to_ram, bus.busy, bus.rd_err};
    vectors++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", o); end
    do_reset();
    repeat (3) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, o, e); end
    end
  endtask

  task automatic test_write_burst();
    logic [OW-1:0] e, o;
    int beat;
    do_reset();
    bus.main_state = SW'(WR_ST);
    for (int k = 0; k < 4; k++) add_op(0, 1, k, k);
    apply_ports();
    beat = 0;
    repeat (8) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL write_burst cyc %0d: got %h want %h", cyc, o, e); end
      if (s_ack[0]) begin
        vectors++;
        if (cyc - 1 != beat + 2 || s_addr != AW'(beat) || s_dtr != DW'(beat)) begin
          errors++;
          $display("FAIL write_beat %0d: cyc %0d addr %0d data %0d, want cyc %0d addr/data %0d",
                   beat, cyc - 1, s_addr, s_dtr, beat + 2, beat);
        end
        beat++;
      end
    end
    vectors++;
    if (beat != 4) begin errors++; $display("FAIL write_ack_count: got %0d want 4", beat); end
  endtask

  task automatic test_grant_order();
    logic [OW-1:0] e, o;
    int seq[$];
    int want;
    do_reset();
    bus.main_state = SW'(WR_ST);
    for (int k = 0; k < 12; k++) begin
      add_op(0, 1, k, $urandom_range(0, 65535));
      add_op(1, 1, 256 + k, $urandom_range(0, 65535));
    end
    apply_ports();
    repeat (40) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL grant_order cyc %0d: got %h want %h", cyc, o, e); end
      for (int i = 0; i < NP; i++) if (s_ack[i]) seq.push_back(i);
    end
    vectors++;
    if (seq.size() != 24) begin errors++; $display("FAIL grant_beats: got %0d want 24", seq.size()); end
    for (int n = 0; n < seq.size() && n < 24; n++) begin
      want = (n < 8) ? 0 : (n < 16) ? 1 : (n < 20) ? 0 : 1;
      vectors++;
      if (seq[n] != want) begin errors++; $display("FAIL grant_seq[%0d]: got port %0d want %0d", n, seq[n], want); end
    end
  endtask

  task automatic test_fifo_full();
    logic [OW-1:0] e, o;
    int acks;
    do_reset();
    bus.main_state = SW'(RD_ST);
    for (int k = 0; k < 9; k++) add_op(1, 0, 100 + k, 0);
    apply_ports();
    acks = 0;
    repeat (20) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL fifo_full cyc %0d: got %h want %h", cyc, o, e); end
      if (s_ack[1]) acks++;
    end
    vectors++;
    if (acks != 8 || s_re !== 1'b0 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full_stall: acks %0d re %b busy %b, want 8 0 1", acks, s_re, s_busy);
    end
    bus.rd_data_valid = 1'b1; bus.data_from_ram = 16'hBEEF;
    repeat (4) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL fifo_resume cyc %0d: got %h want %h", cyc, o, e); end
      if (s_ack[1]) acks++;
    end
    vectors++;
    if (acks != 9) begin errors++; $display("FAIL fifo_ninth_ack: got %0d acks want 9", acks); end
    repeat (8) begin
      bus.rd_data_valid = 1'b1; bus.data_from_ram = DW'($urandom);
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL fifo_drain cyc %0d: got %h want %h", cyc, o, e); end
    end
  endtask

  task automatic test_return_order();
    logic [OW-1:0] e, o;
    logic [DW-1:0] vals [3];
    logic [NP-1:0] ports [3];
    vals[0] = 16'hA0A0; vals[1] = 16'hB1B1; vals[2] = 16'hC2C2;
    ports[0] = 2'b01; ports[1] = 2'b10; ports[2] = 2'b01;
    do_reset();
    bus.main_state = SW'(RD_ST);
    add_op(0, 0, 'h10, 0);
    add_op(1, 0, 'h20, 0);
    apply_ports();
    repeat (6) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL return_issue cyc %0d: got %h want %h", cyc, o, e); end
    end
    add_op(0, 0, 'h30, 0);
    apply_ports();
    repeat (6) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL return_issue cyc %0d: got %h want %h", cyc, o, e); end
    end
    for (int n = 0; n < 3; n++) begin
      bus.rd_data_valid = 1'b1; bus.data_from_ram = vals[n];
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL return_strobe cyc %0d: got %h want %h", cyc, o, e); end
      run_cycle(e, o); vectors++;
      if (s_rvalid !== ports[n] || s_rdata !== vals[n]) begin
        errors++;
        $display("FAIL return_data %0d: rvalid %b rdata %h want %b %h", n, s_rvalid, s_rdata, ports[n], vals[n]);
      end
    end
  endtask

  task automatic test_rd_err_and_reset();
    logic [OW-1:0] e, o;
    do_reset();
    bus.rd_data_valid = 1'b1; bus.data_from_ram = 16'h1234;
    run_cycle(e, o);
    run_cycle(e, o); vectors++;
    if (s_err !== 1'b1 || s_rvalid !== '0) begin
      errors++; $display("FAIL rd_err: err %b rvalid %b want 1 00", s_err, s_rvalid);
    end
    bus.main_state = '0;
    for (int k = 0; k < 4; k++) add_op(0, 1, k, 'h55 + k);
    apply_ports();
    repeat (3) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL rd_err_serve cyc %0d: got %h want %h", cyc, o, e); end
    end
    resetn = 1'b0;
    #1;
    o = {bus.p_ack, bus.p_rvalid, bus.p_rdata, bus.write_enable, bus.read_enable,
         bus.i_user_data_address, bus.data_to_ram, bus.busy, bus.rd_err};
    vectors++;
    if (o !== '0) begin errors++; $display("FAIL reset_mid_serve: got %h want 0", o); end
  endtask

  task automatic test_stuck_state();
    logic [OW-1:0] e, o;
    int p0_left;
    do_reset();
    bus.main_state = SW'(RD_ST);
    add_op(0, 1, 7, 'h77); add_op(0, 1, 8, 'h88);
    add_op(1, 1, 9, 'h99);
    apply_ports();
    repeat (20) begin
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL stuck cyc %0d: got %h want %h", cyc, o, e); end
      if (cyc > 2) begin
        vectors++;
        if (s_ack !== '0 || s_we !== 1'b1 || s_addr !== AW'(7)) begin
          errors++; $display("FAIL stuck_hold cyc %0d: ack %b we %b addr %0d want 00 1 7", cyc - 1, s_ack, s_we, s_addr);
        end
      end
    end
    p0_left = port_q[0].size();
    vectors++;
    if (p0_left != 2) begin errors++; $display("FAIL stuck_queue: got %0d ops left want 2", p0_left); end
  endtask

  task automatic test_random();
    logic [OW-1:0] e, o;
    int r;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NP; i++)
        if (port_q[i].size() < 4 && $urandom_range(0, 3) == 0)
          add_op(i, $urandom_range(0, 1), $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 65535));
      apply_ports();
      r = $urandom_range(0, 4);
      bus.main_state = (r < 2) ? SW'(WR_ST) : (r < 4) ? SW'(RD_ST) : SW'($urandom_range(0, 7));
      bus.data_from_ram = DW'($urandom);
      if (m_ids.size() > 0) bus.rd_data_valid = ($urandom_range(0, 3) == 0);
      else                  bus.rd_data_valid = ($urandom_range(0, 63) == 0);
      run_cycle(e, o); vectors++;
      if (o !== e) begin errors++; $display("FAIL random cyc %0d: got %h want %h", cyc, o, e); end
    end
  endtask

  initial begin
    bus.p_req = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.main_state = '0; bus.data_from_ram = '0; bus.rd_data_valid = 1'b0;
    model_reset();
    test_reset();
    test_write_burst();
    test_grant_order();
    test_fifo_full();
    test_return_order();
    test_rd_err_and_reset();
    test_stuck_state();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
